// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one txuartlite between NREQ packet producers.
// A grant lasts a whole packet; a watchdog revokes it from a stalled owner.
module uart_tx_arbiter #(
   parameter int unsigned NREQ    = 3,
   parameter logic [23:0] TIMEOUT = 24'd100000
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic [NREQ-1:0]   i_req,
   input  logic [NREQ-1:0]   i_valid,
   input  logic [8*NREQ-1:0] i_data,
   input  logic [NREQ-1:0]   i_last,
   output logic [NREQ-1:0]   o_grant,
   output logic [NREQ-1:0]   o_ack,
   output logic [NREQ-1:0]   o_abort,
   output logic              o_busy,
   output logic              o_tx_stb,
   output logic [7:0]        o_tx_data,
   input  logic              i_tx_busy
);

   localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {StIdle, StArm, StGap} state_e;

   state_e          state;
   logic [IdxW-1:0] ptr;
   logic [IdxW-1:0] cur;
   logic [23:0]     wdog;
   logic            last_flag;

   logic [IdxW-1:0] pick;
   logic            pick_found;
   logic [NREQ-1:0] pick_onehot;
   logic [IdxW-1:0] nxt;
   logic            cur_req;
   logic            cur_valid;
   logic            cur_last;
   logic [7:0]      cur_data;

   // First pass covers indices at/after the pointer, second pass the wrapped part.
   always_comb begin
      pick        = '0;
      pick_found  = 1'b0;
      pick_onehot = '0;
      for (int k = 0; k < int'(NREQ); k++) begin
         if (!pick_found && i_req[k] && (IdxW'(k) >= ptr)) begin
            pick       = IdxW'(k);
            pick_found = 1'b1;
         end
      end
      for (int k = 0; k < int'(NREQ); k++) begin
         if (!pick_found && i_req[k]) begin
            pick       = IdxW'(k);
            pick_found = 1'b1;
         end
      end
      for (int k = 0; k < int'(NREQ); k++) begin
         pick_onehot[k] = pick_found && (pick == IdxW'(k));
      end
   end

   always_comb begin
      cur_req   = 1'b0;
      cur_valid = 1'b0;
      cur_last  = 1'b0;
      cur_data  = 8'h00;
      for (int k = 0; k < int'(NREQ); k++) begin
         if (cur == IdxW'(k)) begin
            cur_req   = i_req[k];
            cur_valid = i_valid[k];
            cur_last  = i_last[k];
            cur_data  = i_data[8*k +: 8];
         end
      end
      nxt = (cur == IdxW'(NREQ - 1)) ? '0 : cur + IdxW'(1);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state     <= StIdle;
         ptr       <= '0;
         cur       <= '0;
         wdog      <= '0;
         last_flag <= 1'b0;
         o_grant   <= '0;
         o_ack     <= '0;
         o_abort   <= '0;
         o_busy    <= 1'b0;
         o_tx_stb  <= 1'b0;
         o_tx_data <= 8'h00;
      end else begin
         o_ack    <= '0;
         o_abort  <= '0;
         o_tx_stb <= 1'b0;
         unique case (state)
            StIdle: begin
               if (pick_found) begin
                  o_grant <= pick_onehot;
                  o_busy  <= 1'b1;
                  cur     <= pick;
                  wdog    <= '0;
                  state   <= StArm;
               end
            end
            StArm: begin
               if (cur_valid && cur_req && !i_tx_busy) begin
                  o_tx_data <= cur_data;
                  o_tx_stb  <= 1'b1;
                  o_ack     <= o_grant;
                  last_flag <= cur_last;
                  state     <= StGap;
               end else if (!cur_req) begin
                  o_grant <= '0;
                  o_busy  <= 1'b0;
                  ptr     <= nxt;
                  state   <= StIdle;
               end else if (!i_tx_busy) begin
                  // Watchdog only runs while the UART itself is free to take a byte.
                  if (wdog == TIMEOUT - 24'd1) begin
                     o_abort <= o_grant;
                     o_grant <= '0;
                     o_busy  <= 1'b0;
                     ptr     <= nxt;
                     state   <= StIdle;
                  end else begin
                     wdog <= wdog + 24'd1;
                  end
               end
            end
            StGap: begin
               // One idle cycle lets txuartlite raise busy before the next accept.
               wdog <= '0;
               if (last_flag) begin
                  o_grant <= '0;
                  o_busy  <= 1'b0;
                  ptr     <= nxt;
                  state   <= StIdle;
               end else begin
                  state <= StArm;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
